// File: rtl/sum_display_driver_pkg.sv
// Shared types and constants for the 4-digit sum display driver:
// digit-slot encoding, active-low segment patterns and anode helpers.
package sum_display_driver_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F.
  function automatic logic [6:0] seg_digit(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  function automatic logic [3:0] an_pattern(input digit_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sum_display_driver_seg7_encode.sv
// Combinational nibble-to-segment encoder with a blanking override.
module seg7_encode
  import sum_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = seg_digit(nibble);
    end
  end

endmodule

// File: rtl/sum_display_driver.sv
// Multiplexed 4-digit 7-segment driver for a 5-bit adder result. The
// displayed value and its radix only change at frame boundaries.
module sum_display_driver
  import sum_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       load,
  input  logic       hex_mode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pending
);

  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             boundary;
  digit_t           idx;
  digit_t           idx_next;

  logic [4:0] shadow;
  logic [4:0] disp;
  logic       disp_hex;

  logic [1:0] tens;
  logic [4:0] rem;
  logic [3:0] dig_nibble;
  logic       dig_blank;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  assign tc       = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign boundary = tc && (idx == DIG3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= DIG0;
    end else begin
      idx <= idx_next;
    end
  end

  always_comb begin
    idx_next = idx;
    if (tc) begin
      case (idx)
        DIG0:    idx_next = DIG1;
        DIG1:    idx_next = DIG2;
        DIG2:    idx_next = DIG3;
        default: idx_next = DIG0;
      endcase
    end
  end

  // A load that lands on the boundary goes straight to disp so it is
  // never left stranded in the shadow for a whole extra frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      disp     <= '0;
      disp_hex <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        shadow <= sum_in;
      end
      if (boundary) begin
        disp     <= load ? sum_in : shadow;
        disp_hex <= hex_mode;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Decimal split by successive compares; tens never exceeds 3 for 0..31.
  always_comb begin
    tens = 2'd0;
    rem  = disp;
    if (disp >= 5'd30) begin
      tens = 2'd3;
      rem  = disp - 5'd30;
    end else if (disp >= 5'd20) begin
      tens = 2'd2;
      rem  = disp - 5'd20;
    end else if (disp >= 5'd10) begin
      tens = 2'd1;
      rem  = disp - 5'd10;
    end
  end

  always_comb begin
    dig_nibble = 4'h0;
    dig_blank  = 1'b1;
    case (idx)
      DIG0: begin
        dig_nibble = disp_hex ? disp[3:0] : rem[3:0];
        dig_blank  = 1'b0;
      end
      DIG1: begin
        dig_nibble = disp_hex ? {3'b000, disp[4]} : {2'b00, tens};
        dig_blank  = !disp_hex && (tens == 2'd0);
      end
      default: begin
        dig_nibble = 4'h0;
        dig_blank  = 1'b1;
      end
    endcase
  end

  seg7_encode u_encode (
    .nibble (dig_nibble),
    .blank  (dig_blank),
    .seg    (seg_next)
  );

  assign an_next = an_pattern(idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver with a 4-cycle digit slot
// (16-cycle frame); cyc counts rising edges since the last reset release.
module tb_sum_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sum_in = 5'd0;
  logic       load = 1'b0;
  logic       hex_mode = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sum_display_driver #(
    .REFRESH_DIV (4),
    .CNT_W       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sum_in   (sum_in),
    .load     (load),
    .hex_mode (hex_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sum;
    logic       hex;
    logic [6:0] dig0;
    logic [6:0] dig1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end else begin
      $display("ok   %s @cyc %0d: %0h", name, cyc, act);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) tick();
  endtask

  // Next cycle index >= cyc whose position within the frame is 'phase'.
  function automatic int next_phase(input int phase);
    int t;
    t = (cyc / 16) * 16 + phase;
    if (t < cyc) t += 16;
    return t;
  endfunction

  function automatic logic [3:0] an_exp(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (((k - 1) / 4) % 4));
  endfunction

  vec_t vecs [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int bad;
    vecs[0]  = '{5'd13, 1'b0, 7'h30, 7'h79};
    vecs[1]  = '{5'd7,  1'b0, 7'h78, 7'h7F};
    vecs[2]  = '{5'd31, 1'b1, 7'h0E, 7'h79};
    vecs[3]  = '{5'd0,  1'b0, 7'h40, 7'h7F};
    vecs[4]  = '{5'd10, 1'b0, 7'h40, 7'h79};
    vecs[5]  = '{5'd29, 1'b0, 7'h10, 7'h24};
    vecs[6]  = '{5'd31, 1'b0, 7'h79, 7'h30};
    vecs[7]  = '{5'd5,  1'b1, 7'h12, 7'h40};
    vecs[8]  = '{5'd30, 1'b0, 7'h40, 7'h30};
    vecs[9]  = '{5'd20, 1'b0, 7'h40, 7'h24};
    vecs[10] = '{5'd26, 1'b1, 7'h08, 7'h79};
    vecs[11] = '{5'd9,  1'b0, 7'h10, 7'h7F};

    // Reset state and scan order after release.
    @(negedge clk);
    @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_pending", pending, 1'b0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("scan_an", an, an_exp(cyc));
      if (k == 2) check("scan_dig0_zero", seg, 7'h40);
      if (k == 6) check("scan_dig1_blank", seg, 7'h7F);
    end

    // Table-driven captures: load mid-frame, observe the following frame.
    for (int i = 0; i < 12; i++) begin
      goto_cyc(next_phase(2));
      sum_in = vecs[i].sum;
      hex_mode = vecs[i].hex;
      load = 1'b1;
      tick();
      load = 1'b0;
      check("vec_pending_set", pending, 1'b1);
      b = (cyc / 16 + 1) * 16;
      goto_cyc(b - 1);
      check("vec_pending_held", pending, 1'b1);
      goto_cyc(b);
      check("vec_pending_clear", pending, 1'b0);
      goto_cyc(b + 2);
      check("vec_an0", an, 4'b1110);
      check("vec_dig0", seg, vecs[i].dig0);
      goto_cyc(b + 6);
      check("vec_an1", an, 4'b1101);
      check("vec_dig1", seg, vecs[i].dig1);
      goto_cyc(b + 10);
      check("vec_dig2_blank", seg, 7'h7F);
      goto_cyc(b + 14);
      check("vec_an3", an, 4'b0111);
      check("vec_dig3_blank", seg, 7'h7F);
      check("vec_dp", dp, 1'b1);
    end

    // Load exactly on the boundary edge: bypasses shadow, pending stays low.
    goto_cyc(next_phase(15));
    sum_in = 5'd22;
    hex_mode = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    b = cyc;
    check("collide_pending0", pending, 1'b0);
    tick();
    check("collide_pending1", pending, 1'b0);
    goto_cyc(b + 2);
    check("collide_dig0", seg, 7'h24);
    goto_cyc(b + 6);
    check("collide_dig1", seg, 7'h24);

    // Back-to-back loads: the last one wins, the first is never shown.
    goto_cyc(next_phase(5));
    sum_in = 5'd4;
    load = 1'b1;
    tick();
    sum_in = 5'd9;
    tick();
    load = 1'b0;
    check("b2b_pending", pending, 1'b1);
    b = (cyc / 16 + 1) * 16;
    bad = 0;
    while (cyc < b + 16) begin
      tick();
      if (seg == 7'h19) bad++;
      if (cyc == b + 2) check("b2b_dig0", seg, 7'h10);
      if (cyc == b + 6) check("b2b_dig1", seg, 7'h7F);
    end
    check("b2b_never_4", bad, 0);

    // Radix change mid-frame is deferred to the next boundary.
    goto_cyc(next_phase(2));
    sum_in = 5'd16;
    hex_mode = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    b = (cyc / 16 + 1) * 16;
    goto_cyc(b + 2);
    check("mode_dec_dig0", seg, 7'h02);
    hex_mode = 1'b1;
    tick();
    check("mode_hold_dig0", seg, 7'h02);
    goto_cyc(b + 6);
    check("mode_hold_dig1", seg, 7'h79);
    goto_cyc(b + 18);
    check("mode_hex_dig0", seg, 7'h40);
    goto_cyc(b + 22);
    check("mode_hex_dig1", seg, 7'h79);

    // Asynchronous reset mid-frame discards a pending capture.
    goto_cyc(next_phase(6));
    sum_in = 5'd25;
    hex_mode = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("arst_pending_before", pending, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1'b1);
    check("arst_pending", pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    tick();
    check("arst_first_an", an, 4'b1110);
    goto_cyc(15);
    check("arst_no_pending", pending, 1'b0);
    goto_cyc(18);
    check("arst_shadow_dig0", seg, 7'h40);
    goto_cyc(22);
    check("arst_shadow_dig1", seg, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
